// File: rtl/exmem_pkg.sv
// exmem_pkg: shared definitions for the EX/MEM pipeline stage register.
//   - control bit indices inside the Ctrl field
//   - occupancy state encoding of the 2-entry skid buffer
//   - packed bundle type grouping Data/Store/RD/Ctrl
package exmem_pkg;

  localparam int EX_S = 15;  // MSB index of data/register fields
  localparam int EX_C = 2;   // MSB index of control field

  localparam int CTRL_MEMW = 0;
  localparam int CTRL_MEMR = 1;
  localparam int CTRL_REGW = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [EX_S:0] data;
    logic [EX_S:0] store;
    logic [EX_S:0] rd;
    logic [EX_C:0] ctrl;
  } exmem_bundle_t;

endpackage

// File: rtl/exmem_entry.sv
// exmem_entry: one bundle register with a valid bit.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_clr      synchronous clear of valid and data (wins over load)
//   i_load     capture i_d and set valid
//   i_d        bundle to capture (flattened, W bits)
//   o_valid    entry holds a bundle
//   o_q        held bundle; all-zero when cleared
module exmem_entry #(
  parameter int W = 51
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);

  logic         r_valid;
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule

// File: rtl/buffer_exmem.sv
// buffer_exmem: EX/MEM pipeline stage register with a 2-entry skid.
// The main entry drives Out*; the skid entry absorbs one bundle when MEM
// stalls, so InReady depends only on held state (and rst), never on OutReady.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   Flush                            synchronous squash of all held entries
//   InValid/InReady                  EX-side handshake
//   InData/InStore/InRD/InCtrl       incoming bundle
//   OutValid/OutReady                MEM-side handshake
//   OutData/OutStore/OutRD/OutCtrl   head bundle
//   Occ                              entries held (0..2)
// Optional (macro EXMEM_FWD_EN): FwdValid/FwdRD/FwdData forwarding tap of the
// head entry, qualified by its RegWrite bit.
//
// state | meaning
// EMPTY | no entry held
// ONE   | main entry valid, skid empty
// TWO   | main and skid valid, InReady low
module buffer_exmem
  import exmem_pkg::*;
#(
  parameter int S = 15,
  parameter int C = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Flush,
  input  logic       InValid,
  output logic       InReady,
  input  logic [S:0] InData,
  input  logic [S:0] InStore,
  input  logic [S:0] InRD,
  input  logic [C:0] InCtrl,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [S:0] OutData,
  output logic [S:0] OutStore,
  output logic [S:0] OutRD,
  output logic [C:0] OutCtrl,
  output logic [1:0] Occ
`ifdef EXMEM_FWD_EN
  ,
  output logic       FwdValid,
  output logic [S:0] FwdRD,
  output logic [S:0] FwdData
`endif
);

  localparam int W = 3 * (S + 1) + C + 1;

  occ_state_t   r_state;
  occ_state_t   w_state_nxt;
  logic         w_accept;
  logic         w_pop;
  logic         w_main_load;
  logic         w_main_clr;
  logic         w_main_from_skid;
  logic         w_skid_load;
  logic         w_skid_clr;
  logic         w_main_valid;
  logic         w_skid_valid;
  logic [W-1:0] w_in_bundle;
  logic [W-1:0] w_main_d;
  logic [W-1:0] w_main_q;
  logic [W-1:0] w_skid_q;

  assign w_in_bundle = {InData, InStore, InRD, InCtrl};

  assign InReady  = !w_skid_valid && !rst;
  assign OutValid = w_main_valid;
  assign w_accept = InValid && InReady && !Flush;
  assign w_pop    = w_main_valid && OutReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_clr       = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (Flush) begin
      // A same-cycle pop has already been taken by MEM; nothing else survives.
      w_state_nxt = EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = TWO;
            w_skid_load = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
            w_main_clr  = 1'b1;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_state_nxt      = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_clr  = 1'b1;
          w_skid_clr  = 1'b1;
        end
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_bundle;

  exmem_entry #(.W(W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_main_clr),
    .i_load  (w_main_load),
    .i_d     (w_main_d),
    .o_valid (w_main_valid),
    .o_q     (w_main_q)
  );

  exmem_entry #(.W(W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_skid_clr),
    .i_load  (w_skid_load),
    .i_d     (w_in_bundle),
    .o_valid (w_skid_valid),
    .o_q     (w_skid_q)
  );

  assign {OutData, OutStore, OutRD, OutCtrl} = w_main_q;
  assign Occ = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

`ifdef EXMEM_FWD_EN
  assign FwdValid = w_main_valid && OutCtrl[CTRL_REGW];
  assign FwdRD    = FwdValid ? OutRD : '0;
  assign FwdData  = FwdValid ? OutData : '0;
`endif

endmodule

// File: tb/tb_buffer_exmem.sv
module tb_buffer_exmem;
  import exmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, Flush, InValid, OutReady;
  logic        InReady, OutValid;
  logic [15:0] InData, InStore, InRD;
  logic [2:0]  InCtrl;
  logic [15:0] OutData, OutStore, OutRD;
  logic [2:0]  OutCtrl;
  logic [1:0]  Occ;
`ifdef EXMEM_FWD_EN
  logic        FwdValid;
  logic [15:0] FwdRD, FwdData;
`endif

  buffer_exmem #(.S(15), .C(2)) dut (
    .clk(clk), .rst(rst), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .InData(InData), .InStore(InStore), .InRD(InRD), .InCtrl(InCtrl),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .OutStore(OutStore), .OutRD(OutRD), .OutCtrl(OutCtrl),
    .Occ(Occ)
`ifdef EXMEM_FWD_EN
    , .FwdValid(FwdValid), .FwdRD(FwdRD), .FwdData(FwdData)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of accepted bundles, capacity 2.
  exmem_bundle_t exp_q[$];
  int m_occ = 0;
  int n_checks = 0;
  int n_errs = 0;
  int n_pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares handshake state every cycle and the head bundle
  // whenever the DUT presents one; retires it on a completed pop.
  always @(negedge clk) begin
    chk("occ", {30'd0, Occ}, m_occ);
    chk("in_ready", {31'd0, InReady}, {31'd0, (m_occ < 2) && !rst});
    chk("out_valid", {31'd0, OutValid}, {31'd0, m_occ != 0});
`ifdef EXMEM_FWD_EN
    if (exp_q.size() > 0 && m_occ != 0) begin
      chk("fwd_valid", {31'd0, FwdValid}, {31'd0, exp_q[0].ctrl[2]});
      chk("fwd_rd", {16'd0, FwdRD}, exp_q[0].ctrl[2] ? {16'd0, exp_q[0].rd} : 32'd0);
      chk("fwd_data", {16'd0, FwdData}, exp_q[0].ctrl[2] ? {16'd0, exp_q[0].data} : 32'd0);
    end else begin
      chk("fwd_valid_idle", {31'd0, FwdValid}, 32'd0);
    end
`endif
    if (OutValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_out: got data %0h expected no output at %0t", OutData, $time);
      end else begin
        chk("out_data", {16'd0, OutData}, {16'd0, exp_q[0].data});
        chk("out_store", {16'd0, OutStore}, {16'd0, exp_q[0].store});
        chk("out_rd", {16'd0, OutRD}, {16'd0, exp_q[0].rd});
        chk("out_ctrl", {29'd0, OutCtrl}, {29'd0, exp_q[0].ctrl});
        if (OutReady && !rst) begin
          void'(exp_q.pop_front());
          n_pops++;
        end
      end
    end
  end

  // Drive one cycle of inputs, advance the model across the edge.
  task automatic cyc(input logic inv, input logic [15:0] d, input logic [15:0] st,
                     input logic [15:0] rd, input logic [2:0] ct,
                     input logic ordy, input logic fl, input logic r);
    bit acc, pop;
    exmem_bundle_t b;
    InValid = inv; InData = d; InStore = st; InRD = rd; InCtrl = ct;
    OutReady = ordy; Flush = fl; rst = r;
    pop = (m_occ > 0) && ordy;
    acc = inv && (m_occ < 2) && !fl && !r;
    b.data = d; b.store = st; b.rd = rd; b.ctrl = ct;
    @(posedge clk);
    if (r || fl) begin
      exp_q.delete();
      m_occ = 0;
    end else begin
      if (acc) exp_q.push_back(b);
      m_occ = m_occ - int'(pop) + int'(acc);
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 16'h0, 16'h0, 16'h0, 3'b000, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    int p0;
    rst = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    InData = '0; InStore = '0; InRD = '0; InCtrl = '0;
    cyc(1'b0, 16'h0, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("rst_out_data", {16'd0, OutData}, 32'd0);
    chk("rst_occ", {30'd0, Occ}, 32'd0);
    chk("rst_in_ready", {31'd0, InReady}, 32'd0);
    chk("rst_out_valid", {31'd0, OutValid}, 32'd0);

    // First bundle: one-cycle latency.
    cyc(1'b1, 16'h1234, 16'h0, 16'h0003, 3'b100, 1'b1, 1'b0, 1'b0);
    chk("lat_valid", {31'd0, OutValid}, 32'd1);
    chk("lat_data", {16'd0, OutData}, 32'h1234);
    chk("lat_occ", {30'd0, Occ}, 32'd1);
    idle(1'b1);

    // Streaming with no bubbles.
    p0 = n_pops;
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'(i), 3'(i), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("stream_pops", n_pops - p0, 32'd8);

    // Back-pressure fills the skid.
    cyc(1'b1, 16'hAAAA, 16'h1111, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hBBBB, 16'h2222, 16'h0002, 3'b010, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("bp_occ", {30'd0, Occ}, 32'd2);
    chk("bp_in_ready", {31'd0, InReady}, 32'd0);
    chk("bp_head", {16'd0, OutData}, 32'hAAAA);
    idle(1'b1);
    chk("bp_ready_back", {31'd0, InReady}, 32'd1);
    idle(1'b1);
    idle(1'b1);

    // Flush in TWO with a pop and a dropped input.
    cyc(1'b1, 16'hA2A2, 16'h0, 16'h0004, 3'b001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hB2B2, 16'h0, 16'h0005, 3'b001, 1'b0, 1'b0, 1'b0);
    p0 = n_pops;
    cyc(1'b1, 16'hCCCC, 16'h0, 16'h0006, 3'b100, 1'b1, 1'b1, 1'b0);
    chk("flush_popped", n_pops - p0, 32'd1);
    chk("flush_occ", {30'd0, Occ}, 32'd0);
    chk("flush_valid", {31'd0, OutValid}, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Mid-stream reset with two entries held.
    cyc(1'b1, 16'hD1D1, 16'h0, 16'h0007, 3'b110, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hD2D2, 16'h0, 16'h0008, 3'b110, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("mrst_data", {16'd0, OutData}, 32'd0);
    chk("mrst_occ", {30'd0, Occ}, 32'd0);
    chk("mrst_in_ready", {31'd0, InReady}, 32'd0);
    idle(1'b1);
    chk("mrst_ready_after", {31'd0, InReady}, 32'd1);
    idle(1'b1);

`ifdef EXMEM_FWD_EN
    cyc(1'b1, 16'h00FF, 16'h0, 16'h0005, 3'b100, 1'b0, 1'b0, 1'b0);
    chk("fwd_dir_valid", {31'd0, FwdValid}, 32'd1);
    chk("fwd_dir_rd", {16'd0, FwdRD}, 32'h5);
    chk("fwd_dir_data", {16'd0, FwdData}, 32'h00FF);
    idle(1'b1);
    cyc(1'b1, 16'h00FF, 16'h0, 16'h0005, 3'b001, 1'b0, 1'b0, 1'b0);
    chk("fwd_dir_nv", {31'd0, FwdValid}, 32'd0);
    chk("fwd_dir_nrd", {16'd0, FwdRD}, 32'd0);
    chk("fwd_dir_ndata", {16'd0, FwdData}, 32'd0);
    idle(1'b1);
`endif

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
          3'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 150) == 0);
    end

    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
